coeff_load_sequencer: RTL and testbench

Sequences one full coefficient load for the 8-band equalizer. On request, it reads 64 signed 16-bit taps for the selected band from a synchronous coefficient ROM. It streams them into the filter's coefficient-write port (write enable, address, data), then issues a single write-done strobe. It sits between the band-select/control logic and the filter's registered coefficient-input stage.

---
 rtl/eq_coeff_pkg.sv | 30 +++
 rtl/coeff_load_sequencer_if.sv | 29 ++
 rtl/coeff_load_sequencer_tap_counter.sv | 29 ++
 rtl/coeff_load_sequencer.sv | 117 +++++++++++
 tb/tb_coeff_load_sequencer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/eq_coeff_pkg.sv
// Shared constants, state encoding and address helper for the equalizer
// coefficient-load path.
package eq_coeff_pkg;

  localparam int NUM_TAPS   = 64;
  localparam int ADDR_W     = 6;
  localparam int BAND_W     = 3;
  localparam int COEFF_W    = 16;
  localparam int ROM_ADDR_W = BAND_W + ADDR_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } load_state_t;

  // Tap index the ROM must be fetching while tap n is being written:
  // two ahead, pinned at the last tap so the address never leaves the band.
  function automatic logic [ADDR_W-1:0] rom_lookahead(input logic [ADDR_W-1:0] n);
    logic [ADDR_W:0] sum;
    sum = {1'b0, n} + (ADDR_W+1)'(2);
    if (sum > (ADDR_W+1)'(NUM_TAPS - 1)) begin
      return ADDR_W'(NUM_TAPS - 1);
    end else begin
      return sum[ADDR_W-1:0];
    end
  endfunction

endpackage

// File: rtl/coeff_load_sequencer_if.sv
// Request, ROM and filter coefficient-write signals of the load sequencer.
// The master side is the sequencer itself; the slave side is its environment.
interface coeff_load_sequencer_if;
  import eq_coeff_pkg::*;

  logic                         i_load_req;
  logic [BAND_W-1:0]            i_load_band;
  logic                         o_load_busy;
  logic                         o_load_done;
  logic [ROM_ADDR_W-1:0]        o_rom_addr;
  logic signed [COEFF_W-1:0]    i_rom_data;
  logic                         o_write_enable;
  logic [ADDR_W-1:0]            o_write_address;
  logic signed [COEFF_W-1:0]    o_coeffs_in;
  logic                         o_write_done;

  modport master (
    input  i_load_req, i_load_band, i_rom_data,
    output o_load_busy, o_load_done, o_rom_addr,
           o_write_enable, o_write_address, o_coeffs_in, o_write_done
  );

  modport slave (
    output i_load_req, i_load_band, i_rom_data,
    input  o_load_busy, o_load_done, o_rom_addr,
           o_write_enable, o_write_address, o_coeffs_in, o_write_done
  );

endinterface

// File: rtl/coeff_load_sequencer_tap_counter.sv
// Tap index counter: synchronous clear (priority), count enable and a
// terminal flag at the last tap of a band.
module tap_counter
  import eq_coeff_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  output logic [ADDR_W-1:0] count,
  output logic              terminal
);

  // Count taps; clear wins over enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + ADDR_W'(1);
    end else begin
      count <= count;
    end
  end

  assign terminal = (count == ADDR_W'(NUM_TAPS - 1));

endmodule

// File: rtl/coeff_load_sequencer.sv
// Coefficient load sequencer: on request, reads the 64 taps of one band from
// a synchronous ROM (one enabled cycle latency) and streams them to the
// filter's coefficient-write port, followed by a single write-done strobe.
module coeff_load_sequencer
  import eq_coeff_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clk_enable,
  coeff_load_sequencer_if.master bus
);

  load_state_t               state;
  logic [BAND_W-1:0]         band;
  logic                      load_busy;
  logic                      load_done;
  logic [ROM_ADDR_W-1:0]     rom_addr;
  logic                      write_enable;
  logic [ADDR_W-1:0]         write_address;
  logic signed [COEFF_W-1:0] coeffs_in;
  logic                      write_done;

  logic [ADDR_W-1:0]         tap_count;
  logic                      tap_last;
  logic                      tap_clear;
  logic                      tap_advance;

  // The write index only moves while streaming and restarts at 0 otherwise.
  assign tap_advance = clk_enable && (state == STREAM);
  assign tap_clear   = clk_enable && (state != STREAM);

  tap_counter u_tap_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (tap_clear),
    .enable   (tap_advance),
    .count    (tap_count),
    .terminal (tap_last)
  );

  // Load sequencing FSM with all outputs registered; nothing moves while
  // clk_enable is low so stalls never drop or repeat a tap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      band          <= '0;
      load_busy     <= 1'b0;
      load_done     <= 1'b0;
      rom_addr      <= '0;
      write_enable  <= 1'b0;
      write_address <= '0;
      coeffs_in     <= '0;
      write_done    <= 1'b0;
    end else if (clk_enable) begin
      case (state)
        IDLE: begin
          load_done     <= 1'b0;
          write_done    <= 1'b0;
          write_enable  <= 1'b0;
          write_address <= '0;
          coeffs_in     <= '0;
          if (bus.i_load_req) begin
            band      <= bus.i_load_band;
            rom_addr  <= {bus.i_load_band, ADDR_W'(0)};
            load_busy <= 1'b1;
            state     <= PRIME;
          end else begin
            rom_addr  <= '0;
            load_busy <= 1'b0;
            state     <= IDLE;
          end
        end
        PRIME: begin
          // Tap 0 is already in flight; fetch tap 1 behind it.
          rom_addr <= {band, ADDR_W'(1)};
          state    <= STREAM;
        end
        STREAM: begin
          write_enable  <= 1'b1;
          write_address <= tap_count;
          coeffs_in     <= bus.i_rom_data;
          rom_addr      <= {band, rom_lookahead(tap_count)};
          if (tap_last) begin
            state <= DONE;
          end else begin
            state <= STREAM;
          end
        end
        DONE: begin
          write_enable <= 1'b0;
          write_done   <= 1'b1;
          load_done    <= 1'b1;
          state        <= IDLE;
        end
        default: begin
          load_busy     <= 1'b0;
          load_done     <= 1'b0;
          rom_addr      <= '0;
          write_enable  <= 1'b0;
          write_address <= '0;
          coeffs_in     <= '0;
          write_done    <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_load_busy     = load_busy;
  assign bus.o_load_done     = load_done;
  assign bus.o_rom_addr      = rom_addr;
  assign bus.o_write_enable  = write_enable;
  assign bus.o_write_address = write_address;
  assign bus.o_coeffs_in     = coeffs_in;
  assign bus.o_write_done    = write_done;

endmodule

// File: tb/tb_coeff_load_sequencer.sv
// Bench for coeff_load_sequencer: a timing-rule reference model predicts
// every write and done strobe by enabled-edge number into a scoreboard, and
// a monitor compares the DUT after each enabled edge.
module tb_coeff_load_sequencer;
  import eq_coeff_pkg::*;

  logic clk        = 1'b0;
  logic rst        = 1'b1;
  logic clk_enable = 1'b1;
  bit   stall_mode = 1'b0;
  bit   extreme    = 1'b0;

  coeff_load_sequencer_if bus();

  coeff_load_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .clk_enable (clk_enable),
    .bus        (bus)
  );

  typedef struct {
    bit          is_done;
    int          edge_id;
    logic [5:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   ecnt      = 0;
  int   next_free = 0;
  int   last_acc  = 0;
  int   acc_cnt   = 0;
  int   n_checks  = 0;
  int   n_fail    = 0;

  always #5 clk = ~clk;

  // Coefficient ROM contents: band*256+index, with optional signed extremes.
  function automatic logic [15:0] rom_value(input logic [2:0] b, input int idx);
    if (extreme && idx == 0) return 16'h8000;
    if (extreme && idx == NUM_TAPS - 1) return 16'h7FFF;
    return 16'(int'(b) * 256 + idx);
  endfunction

  // Synchronous ROM sharing the global enable.
  always @(posedge clk) begin
    if (clk_enable) bus.i_rom_data <= rom_value(bus.o_rom_addr[8:6], int'(bus.o_rom_addr[5:0]));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t, edge %0d)", name, act, exp, $time, ecnt);
    end
  endtask

  task automatic report_missed(input string name, input int edge_id);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event due at edge %0d not seen, now edge %0d", name, edge_id, ecnt);
  endtask

  // Reference model (accept/timing rules) plus monitor, one process per edge.
  always @(posedge clk) begin : scoreboard
    exp_t e;
    if (rst) begin
      sb.delete();
      next_free = 0;
    end else if (clk_enable) begin
      ecnt++;
      if (ecnt >= next_free && bus.i_load_req === 1'b1) begin
        last_acc  = ecnt;
        next_free = ecnt + 67;
        acc_cnt++;
        for (int i = 0; i < NUM_TAPS; i++) begin
          e.is_done = 1'b0;
          e.edge_id = ecnt + 2 + i;
          e.addr    = 6'(i);
          e.data    = rom_value(bus.i_load_band, i);
          sb.push_back(e);
        end
        e.is_done = 1'b1;
        e.edge_id = ecnt + 66;
        e.addr    = 6'd0;
        e.data    = 16'd0;
        sb.push_back(e);
      end
      #1;
      if (!rst) begin
        chk("busy", {31'd0, bus.o_load_busy}, {31'd0, (ecnt < next_free)});
        while (sb.size() > 0 && sb[0].edge_id < ecnt) begin
          e = sb.pop_front();
          report_missed(e.is_done ? "missed_done" : "missed_write", e.edge_id);
        end
        if (sb.size() > 0 && sb[0].edge_id == ecnt) begin
          e = sb.pop_front();
          if (e.is_done) begin
            chk("done_write_enable", {31'd0, bus.o_write_enable}, 32'd0);
            chk("write_done", {31'd0, bus.o_write_done}, 32'd1);
            chk("load_done", {31'd0, bus.o_load_done}, 32'd1);
          end else begin
            chk("write_enable", {31'd0, bus.o_write_enable}, 32'd1);
            chk("write_address", {26'd0, bus.o_write_address}, {26'd0, e.addr});
            chk("coeff_data", {16'd0, bus.o_coeffs_in}, {16'd0, e.data});
            chk("stream_write_done", {31'd0, bus.o_write_done}, 32'd0);
          end
        end else begin
          chk("idle_write_enable", {31'd0, bus.o_write_enable}, 32'd0);
          chk("idle_write_done", {31'd0, bus.o_write_done}, 32'd0);
          chk("idle_load_done", {31'd0, bus.o_load_done}, 32'd0);
        end
      end
    end
  end

  // Global enable: steady high, or pseudo-random while stalling.
  initial begin
    forever begin
      @(negedge clk);
      clk_enable = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, bus.o_load_busy}, 32'd0);
    chk({tag, "_load_done"}, {31'd0, bus.o_load_done}, 32'd0);
    chk({tag, "_rom_addr"}, {23'd0, bus.o_rom_addr}, 32'd0);
    chk({tag, "_write_enable"}, {31'd0, bus.o_write_enable}, 32'd0);
    chk({tag, "_write_address"}, {26'd0, bus.o_write_address}, 32'd0);
    chk({tag, "_coeffs_in"}, {16'd0, bus.o_coeffs_in}, 32'd0);
    chk({tag, "_write_done"}, {31'd0, bus.o_write_done}, 32'd0);
  endtask

  task automatic wait_accept(input int prev);
    int n = 0;
    while (acc_cnt == prev && n < 500) begin
      @(posedge clk); #2; n++;
    end
    chk("request_accepted", {31'd0, (acc_cnt != prev)}, 32'd1);
  endtask

  task automatic wait_edge(input int target);
    int n = 0;
    while (ecnt < target && n < 2000) begin
      @(posedge clk); #2; n++;
    end
    chk("edge_reached", {31'd0, (ecnt >= target)}, 32'd1);
  endtask

  task automatic start_load(input logic [2:0] b);
    int prev = acc_cnt;
    @(negedge clk);
    bus.i_load_req  = 1'b1;
    bus.i_load_band = b;
    wait_accept(prev);
    @(negedge clk);
    bus.i_load_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((ecnt < next_free || sb.size() != 0) && n < 3000) begin
      @(posedge clk); #2; n++;
    end
    chk("load_completed", {31'd0, (ecnt >= next_free && sb.size() == 0)}, 32'd1);
  endtask

  // Directed scenarios followed by a few randomized loads.
  initial begin
    int prev;
    bus.i_load_req  = 1'b0;
    bus.i_load_band = 3'd0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single load of band 5.
    start_load(3'd5);
    wait_idle();

    // Band 2 under a pseudo-random enable.
    stall_mode = 1'b1;
    start_load(3'd2);
    wait_idle();
    stall_mode = 1'b0;

    // Band 7 request during a band 1 load must be ignored.
    start_load(3'd1);
    wait_edge(last_acc + 10);
    @(negedge clk);
    bus.i_load_req  = 1'b1;
    bus.i_load_band = 3'd7;
    wait_edge(last_acc + 20);
    @(negedge clk);
    bus.i_load_req = 1'b0;
    wait_idle();

    // Back-to-back: request held, band 0 then band 3.
    prev = acc_cnt;
    @(negedge clk);
    bus.i_load_req  = 1'b1;
    bus.i_load_band = 3'd0;
    wait_accept(prev);
    @(negedge clk);
    bus.i_load_band = 3'd3;
    wait_accept(prev + 1);
    @(negedge clk);
    bus.i_load_req = 1'b0;
    wait_idle();

    // Asynchronous reset once write index 30 has been registered.
    start_load(3'd6);
    wait_edge(last_acc + 32);
    rst = 1'b1;
    #1;
    check_all_zero("midload_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    start_load(3'd4);
    wait_idle();

    // Signed extremes at taps 0 and 63.
    extreme = 1'b1;
    start_load(3'd6);
    wait_idle();
    extreme = 1'b0;

    // Randomized bands and enable patterns.
    for (int k = 0; k < 3; k++) begin
      stall_mode = 1'($urandom_range(0, 1));
      start_load(3'($urandom_range(0, 7)));
      wait_idle();
    end
    stall_mode = 1'b0;

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
